// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    // Handshake: start is sampled every rising edge and is taken only while busy=0
    // (idle or the done cycle), capturing a/b/cin on that edge. busy is high while bits
    // are being shifted; done is a one-cycle pulse during which sum/cout hold the new result.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_fa_stage.sv
// One-bit full adder made of two half adders whose carries are ORed together.
module fa_stage (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic sum,
    output logic carry
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    assign ha0_sum   = x ^ y;
    assign ha0_carry = x & y;
    assign sum       = ha0_sum ^ z;
    assign ha1_carry = ha0_sum & z;
    assign carry     = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage reused over WIDTH clock edges, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus,
    output state_t         fsm_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum;
    logic             fa_carry;

    fa_stage u_fa (
        .x     (op_a[0]),
        .y     (op_b[0]),
        .z     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            psum   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_a  <= bus.a;
                        op_b  <= bus.b;
                        carry <= bus.cin;
                        psum  <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= fa_carry;
                    // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                    psum  <= {fa_sum, psum[WIDTH-1:1]};
                    if (cnt == LAST_BIT) begin
                        sum_q  <= {fa_sum, psum[WIDTH-1:1]};
                        cout_q <= fa_carry;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state == SHIFT);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;
    import serial_adder_pkg::*;

    logic   clk;
    logic   rst;
    state_t fsm_state;
    int     checks;
    int     errors;

    serial_adder_if #(.WIDTH(8)) bus ();

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          output logic [7:0] s, output logic c, output int lat, output bit seen);
        bus.a     = ta;
        bus.b     = tb_v;
        bus.cin   = tc;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
        end
        s = bus.sum;
        c = bus.cout;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        bus.cin = 1'b1;
        step();
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b expected busy=0 done=0", bus.busy, bus.done);
        end
        checks++;
        if (bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_result sum=%h cout=%b expected sum=00 cout=0", bus.sum, bus.cout);
        end
        checks++;
        if (fsm_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state state=%0d expected %0d", fsm_state, IDLE);
        end
        rst = 1'b0;
        step();
        checks++;
        if (fsm_state !== IDLE || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release state=%0d busy=%b expected IDLE busy=0", fsm_state, bus.busy);
        end
    endtask

    task automatic test_zero();
        int  busy_cycles;
        bit  seen;
        busy_cycles = 0;
        seen = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cycles++;
            step();
        end
        checks++;
        if (!seen || busy_cycles != 8) begin
            errors++;
            $display("FAIL zero_busy_len busy_cycles=%0d done_seen=%0d expected 8 and 1", busy_cycles, seen);
        end
        checks++;
        if (bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL zero_result sum=%h cout=%b expected 00 0", bus.sum, bus.cout);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || fsm_state !== IDLE) begin
            errors++;
            $display("FAIL zero_done_width done=%b busy=%b state=%0d expected 0 0 IDLE",
                     bus.done, bus.busy, fsm_state);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va   [6] = '{8'hFF, 8'hA5, 8'h3C, 8'hFF, 8'h7F, 8'h55};
        logic [7:0] vb   [6] = '{8'h01, 8'h5A, 8'h42, 8'hFF, 8'h01, 8'h2A};
        logic       vc   [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        logic [8:0] vexp [6] = '{9'h100, 9'h100, 9'h07E, 9'h1FF, 9'h080, 9'h080};
        logic [7:0] s;
        logic       c;
        int         lat;
        bit         seen;
        for (int k = 0; k < 6; k++) begin
            run_op(va[k], vb[k], vc[k], s, c, lat, seen);
            checks++;
            if (!seen || lat != 8) begin
                errors++;
                $display("FAIL vec%0d_latency lat=%0d seen=%0d expected 8 1", k, lat, seen);
            end
            checks++;
            if ({c, s} !== vexp[k]) begin
                errors++;
                $display("FAIL vec%0d_result got=%h expected=%h", k, {c, s}, vexp[k]);
            end
            step();
        end
    endtask

    task automatic test_start_ignored();
        int         pulses;
        bit         moved;
        logic [7:0] prev;
        logic [7:0] got_sum;
        logic       got_cout;
        pulses = 0;
        moved = 1'b0;
        got_sum = 8'hxx;
        got_cout = 1'bx;
        prev = bus.sum;
        bus.a = 8'h10;
        bus.b = 8'h20;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        bus.cin = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                pulses++;
                got_sum = bus.sum;
                got_cout = bus.cout;
            end else if (bus.busy === 1'b1 && bus.sum !== prev) begin
                moved = 1'b1;
            end
            step();
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ignore_pulses pulses=%0d expected 1", pulses);
        end
        checks++;
        if (got_sum !== 8'h30 || got_cout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result sum=%h cout=%b expected 30 0", got_sum, got_cout);
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL ignore_hold sum changed during SHIFT, expected held at %h", prev);
        end
    endtask

    task automatic test_reset_mid();
        int         pulses;
        logic [7:0] s;
        logic       c;
        int         lat;
        bit         seen;
        pulses = 0;
        bus.a = 8'h80;
        bus.b = 8'h80;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        bus.start = 1'b1;
        step();
        rst = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs busy=%b done=%b sum=%h cout=%b expected 0 0 00 0",
                     bus.busy, bus.done, bus.sum, bus.cout);
        end
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midrst_no_done pulses=%0d expected 0", pulses);
        end
        run_op(8'h01, 8'h02, 1'b0, s, c, lat, seen);
        checks++;
        if (!seen || lat != 8 || {c, s} !== 9'h003) begin
            errors++;
            $display("FAIL midrst_restart got=%h lat=%0d seen=%0d expected 003 8 1", {c, s}, lat, seen);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int  first_lat;
        int  period;
        bit  moved;
        bit  seen;
        first_lat = 0;
        period = 0;
        moved = 1'b0;
        seen = 1'b0;
        bus.a = 8'h01;
        bus.b = 8'h01;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        step();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.done === 1'b1) begin
                first_lat = i;
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || first_lat != 8 || bus.sum !== 8'h02 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first lat=%0d sum=%h cout=%b expected 8 02 0", first_lat, bus.sum, bus.cout);
        end
        bus.a = 8'h02;
        bus.b = 8'h02;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.done === 1'b1) begin
                period = i;
                seen = 1'b1;
                break;
            end
            if (bus.sum !== 8'h02) moved = 1'b1;
        end
        checks++;
        if (!seen || period != 9) begin
            errors++;
            $display("FAIL b2b_period period=%0d seen=%0d expected 9 1", period, seen);
        end
        checks++;
        if (bus.sum !== 8'h04 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second sum=%h cout=%b expected 04 0", bus.sum, bus.cout);
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL b2b_hold sum left 02 between pulses");
        end
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h04) begin
            errors++;
            $display("FAIL b2b_idle busy=%b done=%b sum=%h expected 0 0 04", bus.busy, bus.done, bus.sum);
        end
    endtask

    task automatic test_random();
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] exp_v;
        logic [7:0] s;
        logic       c;
        int         lat;
        bit         seen;
        int         bad;
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            exp_v = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            run_op(ra, rb, rc, s, c, lat, seen);
            checks++;
            if (!seen || {c, s} !== exp_v) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL rand%0d a=%h b=%h cin=%b got=%h expected=%h seen=%0d",
                             n, ra, rb, rc, {c, s}, exp_v, seen);
            end
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        test_reset();
        test_zero();
        test_vectors();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
